accel_prog_loader: RTL and testbench
====================================

ACCEL_PROG_LOADER -- requirements
Module: accel_prog_loader

Interface
REQ-001 SHALL have parameter NMVU, default 8, number of MVU channels (1..16).
REQ-002 SHALL have parameter XLEN, default 32, input stream word width.
REQ-003 SHALL have parameter IMEM_AW, default 10, PITO instruction memory address width.
REQ-004 SHALL have parameter DMEM_AW, default 10, PITO data memory address width.
REQ-005 SHALL have parameter WA, default 9, MVU weight memory address width.
REQ-006 SHALL have parameter WW, default 128, MVU weight word width; it SHALL be an integer multiple of XLEN.
REQ-007 Ports, one per line:
 clk  in  1  single clock; all logic on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 in_data  in  XLEN  stream word (header or payload)
 in_valid  in  1  stream word valid
 in_ready  out  1  stream word accepted when in_valid&in_ready
 abort  in  1  synchronous packet abort
 pito_imem_addr  out  IMEM_AW  imem write address
 pito_imem_data  out  XLEN  imem write data
 pito_imem_w_en  out  1  imem write strobe
 pito_dmem_addr  out  DMEM_AW  dmem write address
 pito_dmem_data  out  XLEN  dmem write data
 pito_dmem_w_en  out  1  dmem write strobe
 pito_program  out  1  high while an imem packet is in progress
 mvu_wrw_addr  out  WA  weight write address, shared by all channels
 mvu_wrw_word  out  WW  weight write word, shared
 mvu_wrw_en  out  NMVU  one-hot weight write enable
 busy  out  1  packet in progress
 done  out  1  one-cycle pulse, packet completed
 err  out  1  one-cycle pulse, packet rejected

Function
REQ-008 Header word fields SHALL be: [31:30] target (0 imem, 1 dmem, 2 weight, 3 invalid), [29:26] mvu index, [25:14] length-1 in destination writes (1..4096), [13:0] base address, truncated to the target address width.
REQ-009 FSM states SHALL be HDR, DATA, DRAIN; reset state HDR.
REQ-010 HDR: accepted header with valid target (and mvu index < NMVU for target 2) SHALL go to DATA; target 3 or mvu index >= NMVU SHALL go to DRAIN and pulse err next cycle.
REQ-011 in_ready SHALL be 1 in all states; no backpressure from memories.
REQ-012 imem/dmem: each accepted payload word SHALL produce one write, registered, w_en high exactly the cycle after acceptance.
REQ-013 weight: WW/XLEN accepted payload words SHALL assemble one weight word, first word in bits [XLEN-1:0]; mvu_wrw_en bit (mvu index) SHALL be high the cycle after the last constituent word.
REQ-014 Write address SHALL start at base and increment by 1 per write, wrapping modulo 2^(target width).
REQ-015 After write number length, the FSM SHALL return to HDR and pulse done on the same cycle as the final write strobe.
REQ-016 DRAIN SHALL consume length payload words (weight: length*WW/XLEN) with no write strobes, then return to HDR; no done.
REQ-017 abort high SHALL return to HDR next cycle, discard a partially assembled weight word, suppress any write not yet issued, and emit no done/err; abort in HDR SHALL be ignored and wins over a simultaneous in_valid.
REQ-018 pito_program SHALL rise the cycle after an imem header is accepted and fall the cycle after done or abort for that packet.
REQ-019 busy SHALL be high whenever state is not HDR.
REQ-020 Gaps in in_valid SHALL only delay writes; address sequence and data SHALL be unchanged.

Reset
REQ-021 rst_n low SHALL immediately force state HDR, all address, data, enables, pito_program, busy, done, err to 0, assembly buffer and counters cleared; in_ready SHALL be 0 while rst_n is low; a packet interrupted by reset is lost.

Verification
REQ-022 imem hdr base 0x010 len 3, payload A,B,C -> imem writes (0x010,A),(0x011,B),(0x012,C), pito_program high throughout, done once with last write.
REQ-023 weight hdr mvu 2 base 0x1FF len 2, words w0..w7 -> en=0x04 twice, addr 0x1FF then 0x000, words {w3,w2,w1,w0} then {w7,w6,w5,w4}.
REQ-024 weight hdr mvu 9 (NMVU=8) len 1 + 4 words -> err pulse, no en, no done, next header accepted normally.
REQ-025 dmem len 4 with in_valid toggling every cycle -> same 4 dmem writes as gapless run, each one cycle after acceptance.
REQ-026 abort after 2 of 4 weight words -> no mvu_wrw_en, busy 0 next cycle, following imem packet correct.
REQ-027 rst_n low mid imem packet -> all outputs 0 asynchronously, pito_program 0, new header after release processed from HDR.

Source files
------------

// File: rtl/accel_prog_loader.sv
// ============================================================================
//  Module   : accel_prog_loader
//  Purpose  : Splits a header-framed word stream into PITO imem/dmem writes
//             and assembled MVU weight-memory writes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_prog_loader #(
    parameter int NMVU    = 8,
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10,
    parameter int WA      = 9,
    parameter int WW      = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 abort,
    output logic [IMEM_AW-1:0]   pito_imem_addr,
    output logic [XLEN-1:0]      pito_imem_data,
    output logic                 pito_imem_w_en,
    output logic [DMEM_AW-1:0]   pito_dmem_addr,
    output logic [XLEN-1:0]      pito_dmem_data,
    output logic                 pito_dmem_w_en,
    output logic                 pito_program,
    output logic [WA-1:0]        mvu_wrw_addr,
    output logic [WW-1:0]        mvu_wrw_word,
    output logic [NMVU-1:0]      mvu_wrw_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int c_ratio = WW / XLEN;
    localparam int c_sw    = (c_ratio > 1) ? $clog2(c_ratio) : 1;
    localparam logic [c_sw-1:0] c_sub_last = c_sw'(c_ratio - 1);
    localparam logic [c_sw-1:0] c_sub_one  = c_sw'(1);
    localparam logic [NMVU-1:0] c_en_one   = NMVU'(1);

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_target;
    logic [3:0]        r_mvu;
    logic [13:0]       r_addr;
    logic [11:0]       r_cnt;
    logic [c_sw-1:0]   r_sub;
    logic [WW-1:0]     r_buf;

    logic [1:0]        w_hdr_tgt;
    logic [3:0]        w_hdr_mvu;
    logic              w_hdr_ok;
    logic              w_unit_end;
    logic [WW-1:0]     w_asm;

    assign w_hdr_tgt  = in_data[31:30];
    assign w_hdr_mvu  = in_data[29:26];
    assign w_hdr_ok   = (w_hdr_tgt != 2'd3) &&
                        ((w_hdr_tgt != 2'd2) || ({1'b0, w_hdr_mvu} < 5'(NMVU)));
    // Non-weight targets write once per word; weights once per c_ratio words.
    assign w_unit_end = (r_target != 2'd2) || (r_sub == c_sub_last);

    assign in_ready = rst_n;
    assign busy     = (r_state != HDR);

    always_comb begin
        w_asm = r_buf;
        w_asm[r_sub*XLEN +: XLEN] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= HDR;
            r_target       <= '0;
            r_mvu          <= '0;
            r_addr         <= '0;
            r_cnt          <= '0;
            r_sub          <= '0;
            r_buf          <= '0;
            pito_imem_addr <= '0;
            pito_imem_data <= '0;
            pito_imem_w_en <= 1'b0;
            pito_dmem_addr <= '0;
            pito_dmem_data <= '0;
            pito_dmem_w_en <= 1'b0;
            pito_program   <= 1'b0;
            mvu_wrw_addr   <= '0;
            mvu_wrw_word   <= '0;
            mvu_wrw_en     <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            pito_imem_w_en <= 1'b0;
            pito_dmem_w_en <= 1'b0;
            mvu_wrw_en     <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            if (done) begin
                pito_program <= 1'b0;
            end
            case (r_state)
                HDR: begin
                    if (in_valid) begin
                        r_target <= w_hdr_tgt;
                        r_mvu    <= w_hdr_mvu;
                        r_addr   <= in_data[13:0];
                        r_cnt    <= in_data[25:14];
                        r_sub    <= '0;
                        if (w_hdr_ok) begin
                            r_state      <= DATA;
                            pito_program <= (w_hdr_tgt == 2'd0);
                        end else begin
                            r_state <= DRAIN;
                            err     <= 1'b1;
                        end
                    end
                end
                DATA, DRAIN: begin
                    if (abort) begin
                        r_state      <= HDR;
                        r_sub        <= '0;
                        r_buf        <= '0;
                        pito_program <= 1'b0;
                    end else if (in_valid) begin
                        if (w_unit_end) begin
                            r_sub  <= '0;
                            r_addr <= r_addr + 14'd1;
                            if (r_cnt == 12'd0) begin
                                r_state <= HDR;
                            end else begin
                                r_cnt <= r_cnt - 12'd1;
                            end
                            // DRAIN walks the same counters but never strobes.
                            if (r_state == DATA) begin
                                done <= (r_cnt == 12'd0);
                                case (r_target)
                                    2'd0: begin
                                        pito_imem_addr <= r_addr[IMEM_AW-1:0];
                                        pito_imem_data <= in_data;
                                        pito_imem_w_en <= 1'b1;
                                    end
                                    2'd1: begin
                                        pito_dmem_addr <= r_addr[DMEM_AW-1:0];
                                        pito_dmem_data <= in_data;
                                        pito_dmem_w_en <= 1'b1;
                                    end
                                    default: begin
                                        mvu_wrw_addr <= r_addr[WA-1:0];
                                        mvu_wrw_word <= w_asm;
                                        mvu_wrw_en   <= c_en_one << r_mvu;
                                    end
                                endcase
                            end
                        end else begin
                            r_sub <= r_sub + c_sub_one;
                            r_buf <= w_asm;
                        end
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_accel_prog_loader.sv
// ============================================================================
//  Module   : tb_accel_prog_loader
//  Purpose  : Directed vector table plus hand sequences for accel_prog_loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_prog_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [9:0]   pito_imem_addr;
    logic [31:0]  pito_imem_data;
    logic         pito_imem_w_en;
    logic [9:0]   pito_dmem_addr;
    logic [31:0]  pito_dmem_data;
    logic         pito_dmem_w_en;
    logic         pito_program;
    logic [8:0]   mvu_wrw_addr;
    logic [127:0] mvu_wrw_word;
    logic [7:0]   mvu_wrw_en;
    logic         busy;
    logic         done;
    logic         err;

    accel_prog_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .abort          (abort),
        .pito_imem_addr (pito_imem_addr),
        .pito_imem_data (pito_imem_data),
        .pito_imem_w_en (pito_imem_w_en),
        .pito_dmem_addr (pito_dmem_addr),
        .pito_dmem_data (pito_dmem_data),
        .pito_dmem_w_en (pito_dmem_w_en),
        .pito_program   (pito_program),
        .mvu_wrw_addr   (mvu_wrw_addr),
        .mvu_wrw_word   (mvu_wrw_word),
        .mvu_wrw_en     (mvu_wrw_en),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         ab;
        logic [31:0]  d;
        logic         ie;
        logic         de;
        logic [7:0]   we;
        logic [13:0]  a;
        logic [127:0] wd;
        logic         dn;
        logic         er;
        logic         bz;
        logic         pg;
    } vec_t;

    vec_t tbl[$];
    int   n_total  = 0;
    int   n_passed = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] h(input logic [1:0] t, input logic [3:0] m,
                                      input int len, input logic [13:0] b);
        return {t, m, 12'(len - 1), b};
    endfunction

    function automatic logic [31:0] w(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic add(input logic v, input logic ab, input logic [31:0] d,
                       input logic ie, input logic de, input logic [7:0] we,
                       input logic [13:0] a, input logic [127:0] wd,
                       input logic dn, input logic er, input logic bz, input logic pg);
        vec_t r;
        r.v = v; r.ab = ab; r.d = d; r.ie = ie; r.de = de; r.we = we;
        r.a = a; r.wd = wd; r.dn = dn; r.er = er; r.bz = bz; r.pg = pg;
        tbl.push_back(r);
    endtask

    task automatic nw(input logic v, input logic ab, input logic [31:0] d,
                      input logic dn, input logic er, input logic bz, input logic pg);
        add(v, ab, d, 1'b0, 1'b0, 8'h00, 14'h0, 128'h0, dn, er, bz, pg);
    endtask

    function automatic logic [155:0] act_cat();
        logic [13:0]  aa;
        logic [127:0] ad;
        if (pito_imem_w_en) begin
            aa = 14'(pito_imem_addr); ad = 128'(pito_imem_data);
        end else if (pito_dmem_w_en) begin
            aa = 14'(pito_dmem_addr); ad = 128'(pito_dmem_data);
        end else if (|mvu_wrw_en) begin
            aa = 14'(mvu_wrw_addr); ad = mvu_wrw_word;
        end else begin
            aa = '0; ad = '0;
        end
        return {pito_imem_w_en, pito_dmem_w_en, mvu_wrw_en, done, err, busy,
                pito_program, aa, ad};
    endfunction

    function automatic logic [235:0] all_outs();
        return {in_ready, pito_imem_addr, pito_imem_data, pito_imem_w_en,
                pito_dmem_addr, pito_dmem_data, pito_dmem_w_en, pito_program,
                mvu_wrw_addr, mvu_wrw_word, mvu_wrw_en, busy, done, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] wa, wb;
    int           long_errs;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
        wa = {w(3), w(2), w(1), w(0)};
        wb = {w(7), w(6), w(5), w(4)};

        // Three-word imem packet, base 0x010.
        nw (1, 0, h(0, 0, 3, 14'h010),                               0, 0, 1, 1);
        add(1, 0, 32'hA0A0_0001, 1, 0, 0, 14'h010, 128'hA0A0_0001,    0, 0, 1, 1);
        add(1, 0, 32'hB0B0_0002, 1, 0, 0, 14'h011, 128'hB0B0_0002,    0, 0, 1, 1);
        add(1, 0, 32'hC0C0_0003, 1, 0, 0, 14'h012, 128'hC0C0_0003,    1, 0, 0, 1);
        nw (0, 0, 32'h0,                                             0, 0, 0, 0);
        // Weight packet, mvu 2, base wraps from 0x1FF to 0x000.
        nw (1, 0, h(2, 2, 2, 14'h1FF),                               0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3)      add(1, 0, w(i), 0, 0, 8'h04, 14'h1FF, wa, 0, 0, 1, 0);
            else if (i == 7) add(1, 0, w(i), 0, 0, 8'h04, 14'h000, wb, 1, 0, 0, 0);
            else             nw (1, 0, w(i), 0, 0, 1, 0);
        end
        // Out-of-range mvu: drained 4 words, error pulse, then a clean dmem packet.
        nw (1, 0, h(2, 9, 1, 14'h0),                                 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) nw(1, 0, w(i), 0, 0, (i != 3), 0);
        nw (1, 0, h(1, 0, 1, 14'h3FF),                               0, 0, 1, 0);
        add(1, 0, 32'hD00D_0001, 0, 1, 0, 14'h3FF, 128'hD00D_0001,    1, 0, 0, 0);
        // Invalid target drains exactly length words.
        nw (1, 0, h(3, 0, 2, 14'h0),                                 0, 1, 1, 0);
        nw (1, 0, 32'h1,                                             0, 0, 1, 0);
        nw (1, 0, 32'h2,                                             0, 0, 0, 0);
        // dmem with valid toggling every cycle.
        nw (1, 0, h(1, 0, 4, 14'h100),                               0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            add(1, 0, 32'hDA7A_0000 | 32'(i), 0, 1, 0, 14'h100 + 14'(i),
                128'(32'hDA7A_0000 | 32'(i)), (i == 3), 0, (i != 3), 0);
            if (i < 3) nw(0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        end
        // Abort ignored in HDR; abort after 2 of 4 weight words.
        nw (1, 1, h(2, 0, 1, 14'h005),                               0, 0, 1, 0);
        nw (1, 0, w(0),                                              0, 0, 1, 0);
        nw (1, 0, w(1),                                              0, 0, 1, 0);
        nw (1, 1, w(2),                                              0, 0, 0, 0);
        nw (1, 0, h(0, 0, 2, 14'h3FF),                               0, 0, 1, 1);
        add(1, 0, 32'h1234_5678, 1, 0, 0, 14'h3FF, 128'h1234_5678,    0, 0, 1, 1);
        add(1, 0, 32'h9ABC_DEF0, 1, 0, 0, 14'h000, 128'h9ABC_DEF0,    1, 0, 0, 1);
        nw (0, 0, 32'h0,                                             0, 0, 0, 0);
        // Abort mid imem packet drops pito_program without done.
        nw (1, 0, h(0, 0, 2, 14'h020),                               0, 0, 1, 1);
        add(1, 0, 32'h0000_00AA, 1, 0, 0, 14'h020, 128'h0000_00AA,    0, 0, 1, 1);
        nw (0, 1, 32'h0,                                             0, 0, 0, 0);
        nw (0, 0, 32'h0,                                             0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 256'(all_outs()), 256'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 256'(in_ready), 256'h1);

        foreach (tbl[k]) begin
            in_valid = tbl[k].v;
            abort    = tbl[k].ab;
            in_data  = tbl[k].d;
            step();
            chk($sformatf("vec[%0d]", k), 256'(act_cat()),
                256'({tbl[k].ie, tbl[k].de, tbl[k].we, tbl[k].dn, tbl[k].er,
                      tbl[k].bz, tbl[k].pg, tbl[k].a, tbl[k].wd}));
        end
        abort = 1'b0;

        // Asynchronous reset in the middle of an imem packet.
        in_valid = 1'b1; in_data = h(0, 0, 3, 14'h040);
        step();
        in_data = 32'h1111_1111;
        step();
        chk("pre_reset_write", 256'({pito_imem_w_en, pito_imem_addr, pito_program}),
            256'({1'b1, 10'h040, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 256'(all_outs()), 256'h0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = h(1, 0, 1, 14'h007);
        step();
        chk("post_reset_hdr", 256'({busy, pito_program, pito_dmem_w_en}), 256'({1'b1, 1'b0, 1'b0}));
        in_data = 32'h2222_2222;
        step();
        chk("post_reset_write", 256'({pito_dmem_w_en, pito_dmem_addr, pito_dmem_data, done, busy, pito_program}),
            256'({1'b1, 10'h007, 32'h2222_2222, 1'b1, 1'b0, 1'b0}));

        // Maximum length 4096, dmem address wraps at 1024.
        long_errs = 0;
        in_data = h(1, 0, 4096, 14'h3FE);
        step();
        for (int i = 0; i < 4096; i++) begin
            in_data = 32'(i);
            step();
            if (!pito_dmem_w_en || pito_dmem_addr != 10'((14'h3FE + i) % 1024) ||
                pito_dmem_data != 32'(i) || (done && i != 4095))
                long_errs++;
        end
        chk("long_writes", 256'(long_errs), 256'h0);
        chk("long_done", 256'({done, busy}), 256'({1'b1, 1'b0}));
        in_valid = 1'b0;
        step();
        chk("long_idle", 256'({done, busy, pito_dmem_w_en}), 256'h0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

`default_nettype wire
